match_flow_ctrl: RTL and testbench
==================================

# match_flow_ctrl

Match sequencing controller for the two-player OLED game. Owns both player scores and decides which screen family drives the two OLED panels: title, live game, or the game-over banner. Point and button events arrive as single-cycle pulses; scores are held stable through the game-over screen so the banner renderer can colour each panel by winner.

## Interface
Parameters:
- WIN_SCORE, 5: score that ends the match; legal range 1..7.
- HOLD_CYCLES, 50_000_000: freeze length after each point, in clock cycles; must be ≥1.
- GAMEOVER_CYCLES, 300_000_000: game-over display time before auto-return; used only with the macro in Configuration.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
- basys3_clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- start_pulse  in  1  one-cycle start request (debounced button).
- restart_pulse  in  1  one-cycle abort/return-to-title request.
- point_p1  in  1  one-cycle pulse; P1 scored.
- point_p2  in  1  one-cycle pulse; P2 scored.
- score1  out  3  P1 score, registered.
- score2  out  3  P2 score, registered.
- screen_sel  out  2  00 title, 01 game, 10 game-over; 11 never driven.
- game_active  out  1  1 only in PLAY; gameplay logic advances only when high.
- point_flash  out  1  1 only in HOLD.
- winner  out  2  00 none, 01 P1, 10 P2; non-zero only in GAMEOVER.

## Operation
- States: TITLE, PLAY, HOLD, GAMEOVER.
- TITLE: screen_sel=00. start_pulse → PLAY; score1 and score2 clear to 0 on the same edge.
- PLAY: screen_sel=01, game_active=1.
  - Exactly one point pulse increments that player's score. Next state is GAMEOVER if the new score equals WIN_SCORE, else HOLD. The hold counter loads on the same edge.
  - point_p1 and point_p2 both high in one cycle: both ignored, no state change.
- HOLD: screen_sel=01, point_flash=1, game_active=0. Point pulses are ignored. The counter runs HOLD_CYCLES cycles, then the state returns to PLAY.
- GAMEOVER: screen_sel=10. winner=01 if score1>score2, else 10. Scores are frozen. start_pulse and point pulses are ignored.
- restart_pulse in PLAY, HOLD or GAMEOVER → TITLE. Scores are held, not cleared. restart_pulse has priority over point pulses in the same cycle.
- restart_pulse in TITLE: ignored. start_pulse outside TITLE: ignored.
- Scores saturate at WIN_SCORE and never wrap. A tie can never reach GAMEOVER because only one score changes per cycle.

## Timing
- All outputs are registered and derived from state and score registers; no combinational input-to-output path.
- Reset values: state TITLE, score1=0, score2=0, screen_sel=00, game_active=0, point_flash=0, winner=00, hold and gameover counters 0.
- Reset asserted mid-match: every register returns to its reset value on the next edge, regardless of other inputs.
- Point pulse sampled at edge n: new score and the new state (HOLD or GAMEOVER) are visible after edge n. In HOLD, PLAY resumes after edge n+HOLD_CYCLES, so point_flash is high for exactly HOLD_CYCLES cycles.
- Start or restart sampled at edge n: the new state is visible after edge n (1-cycle latency).
- The hold counter is at most 32 bits and is compared against HOLD_CYCLES-1.

## Configuration
- GAMEOVER_AUTORESTART_EN defined: GAMEOVER starts a counter on entry. After GAMEOVER_CYCLES cycles the state moves to TITLE with scores held. restart_pulse still exits early.
- GAMEOVER_AUTORESTART_EN undefined: GAMEOVER is left only via restart_pulse or reset. No counter logic is synthesised.

## Test plan
All scenarios use WIN_SCORE=3, HOLD_CYCLES=4, GAMEOVER_CYCLES=10.
- Reset for 2 cycles, then idle for 5 cycles → screen_sel=00, scores 0/0, game_active=0 throughout.
- start_pulse, then point_p1 at edge n → score1=1 and point_flash=1 after n; game_active=1 again after n+4; point_p2 pulsed during HOLD leaves score2=0.
- From PLAY at 2/0, point_p1 → GAMEOVER, screen_sel=10, winner=01, score1=3. Then start_pulse and point_p2 → no change.
- point_p1 and point_p2 in the same cycle from 1/1 → scores stay 1/1, state stays PLAY.
- restart_pulse together with point_p2 from HOLD or PLAY at 2/1 → TITLE, scores stay 2/1. Then start_pulse → scores 0/0.
- P2 wins 3/1:
  - With GAMEOVER_AUTORESTART_EN defined → winner=10, TITLE after 10 cycles.
  - Without the macro → still GAMEOVER after 20 cycles.
- Reset asserted while in HOLD → all outputs at reset values after the next edge.

Source files
------------

// File: rtl/match_flow_ctrl_if.sv
// Handshake bundle between the match controller and the rest of the OLED game.
// Pulses flow from the button/collision logic (master) into the controller (slave);
// scores and screen-select flow back out to the renderers.
interface match_flow_ctrl_if;
    localparam int unsigned SCORE_W  = 3;
    localparam int unsigned SCREEN_W = 2;
    localparam int unsigned WINNER_W = 2;

    logic                start_pulse;
    logic                restart_pulse;
    logic                point_p1;
    logic                point_p2;
    logic [SCORE_W-1:0]  score1;
    logic [SCORE_W-1:0]  score2;
    logic [SCREEN_W-1:0] screen_sel;
    logic                game_active;
    logic                point_flash;
    logic [WINNER_W-1:0] winner;

    modport master (
        output start_pulse, restart_pulse, point_p1, point_p2,
        input  score1, score2, screen_sel, game_active, point_flash, winner
    );

    modport slave (
        input  start_pulse, restart_pulse, point_p1, point_p2,
        output score1, score2, screen_sel, game_active, point_flash, winner
    );
endinterface

// File: rtl/match_flow_ctrl.sv
// Match sequencing controller: owns both scores and selects the screen family
// (title / live game / game-over). Optional macro GAMEOVER_AUTORESTART_EN adds a
// timed return from the game-over banner to the title screen.
module match_flow_ctrl #(
    parameter int unsigned WIN_SCORE       = 5,
    parameter int unsigned HOLD_CYCLES     = 50_000_000,
    parameter int unsigned GAMEOVER_CYCLES = 300_000_000
) (
    input  logic              basys3_clk,
    input  logic              reset,
    match_flow_ctrl_if.slave  bus
);

    localparam int unsigned SCORE_W  = 3;
    localparam int unsigned CNT_W    = 32;
    localparam int unsigned SCREEN_W = 2;
    localparam int unsigned WINNER_W = 2;

    localparam logic [SCORE_W-1:0]  WIN_S     = SCORE_W'(WIN_SCORE);
    localparam logic [CNT_W-1:0]    HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

    localparam logic [SCREEN_W-1:0] SCR_TITLE = 2'b00;
    localparam logic [SCREEN_W-1:0] SCR_GAME  = 2'b01;
    localparam logic [SCREEN_W-1:0] SCR_OVER  = 2'b10;

    localparam logic [WINNER_W-1:0] WIN_NONE  = 2'b00;
    localparam logic [WINNER_W-1:0] WIN_P1    = 2'b01;
    localparam logic [WINNER_W-1:0] WIN_P2    = 2'b10;

    localparam bit CFG_OK = (WIN_SCORE >= 1) && (WIN_SCORE <= 7) &&
                            (HOLD_CYCLES >= 1) && (GAMEOVER_CYCLES >= 1);

    // Reject parameter sets the score width or counters cannot represent.
    if (!CFG_OK) begin : g_cfg_err
        $error("match_flow_ctrl: illegal WIN_SCORE/HOLD_CYCLES/GAMEOVER_CYCLES");
    end

    typedef enum logic [1:0] {
        ST_TITLE,
        ST_PLAY,
        ST_HOLD,
        ST_GAMEOVER
    } state_t;

    state_t               state, state_nxt;
    logic [SCORE_W-1:0]   score1, score2, score1_nxt, score2_nxt;
    logic [CNT_W-1:0]     hold_cnt, hold_cnt_nxt;
    logic [SCREEN_W-1:0]  screen_sel, screen_sel_nxt;
    logic                 game_active, game_active_nxt;
    logic                 point_flash, point_flash_nxt;
    logic [WINNER_W-1:0]  winner, winner_nxt;
    logic                 p1_only_c, p2_only_c;

`ifdef GAMEOVER_AUTORESTART_EN
    localparam logic [CNT_W-1:0] GO_LAST = CNT_W'(GAMEOVER_CYCLES - 1);
    logic [CNT_W-1:0]     go_cnt, go_cnt_nxt;
`endif

    // Scores never pass the winning value, so they cannot wrap.
    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
        return (s >= WIN_S) ? WIN_S : s + SCORE_W'(1);
    endfunction

    // A simultaneous double point is ambiguous and is dropped entirely.
    assign p1_only_c = bus.point_p1 & ~bus.point_p2;
    assign p2_only_c = bus.point_p2 & ~bus.point_p1;

    // Next state, scores and counters.
    always_comb begin
        state_nxt    = state;
        score1_nxt   = score1;
        score2_nxt   = score2;
        hold_cnt_nxt = hold_cnt;
`ifdef GAMEOVER_AUTORESTART_EN
        go_cnt_nxt   = go_cnt;
`endif
        case (state)
            ST_TITLE: begin
                if (bus.start_pulse) begin
                    state_nxt  = ST_PLAY;
                    score1_nxt = '0;
                    score2_nxt = '0;
                end
            end
            ST_PLAY: begin
                if (bus.restart_pulse) begin
                    state_nxt = ST_TITLE;
                end else if (p1_only_c || p2_only_c) begin
                    if (p1_only_c) begin
                        score1_nxt = sat_inc(score1);
                    end else begin
                        score2_nxt = sat_inc(score2);
                    end
                    hold_cnt_nxt = '0;
`ifdef GAMEOVER_AUTORESTART_EN
                    go_cnt_nxt   = '0;
`endif
                    if ((score1_nxt == WIN_S) || (score2_nxt == WIN_S)) begin
                        state_nxt = ST_GAMEOVER;
                    end else begin
                        state_nxt = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (bus.restart_pulse) begin
                    state_nxt = ST_TITLE;
                end else if (hold_cnt == HOLD_LAST) begin
                    state_nxt = ST_PLAY;
                end else begin
                    hold_cnt_nxt = hold_cnt + CNT_W'(1);
                end
            end
            ST_GAMEOVER: begin
                if (bus.restart_pulse) begin
                    state_nxt = ST_TITLE;
                end
`ifdef GAMEOVER_AUTORESTART_EN
                else if (go_cnt == GO_LAST) begin
                    state_nxt = ST_TITLE;
                end else begin
                    go_cnt_nxt = go_cnt + CNT_W'(1);
                end
`endif
            end
            default: begin
                state_nxt = ST_TITLE;
            end
        endcase
    end

    // Output decode from the upcoming state so every output is a flop.
    always_comb begin
        screen_sel_nxt  = SCR_TITLE;
        game_active_nxt = 1'b0;
        point_flash_nxt = 1'b0;
        winner_nxt      = WIN_NONE;
        case (state_nxt)
            ST_PLAY: begin
                screen_sel_nxt  = SCR_GAME;
                game_active_nxt = 1'b1;
            end
            ST_HOLD: begin
                screen_sel_nxt  = SCR_GAME;
                point_flash_nxt = 1'b1;
            end
            ST_GAMEOVER: begin
                screen_sel_nxt = SCR_OVER;
                winner_nxt     = (score1_nxt > score2_nxt) ? WIN_P1 : WIN_P2;
            end
            default: begin
                screen_sel_nxt = SCR_TITLE;
            end
        endcase
    end

    // State, score, counter and output registers.
    always_ff @(posedge basys3_clk) begin
        if (reset) begin
            state       <= ST_TITLE;
            score1      <= '0;
            score2      <= '0;
            hold_cnt    <= '0;
            screen_sel  <= SCR_TITLE;
            game_active <= 1'b0;
            point_flash <= 1'b0;
            winner      <= WIN_NONE;
`ifdef GAMEOVER_AUTORESTART_EN
            go_cnt      <= '0;
`endif
        end else begin
            state       <= state_nxt;
            score1      <= score1_nxt;
            score2      <= score2_nxt;
            hold_cnt    <= hold_cnt_nxt;
            screen_sel  <= screen_sel_nxt;
            game_active <= game_active_nxt;
            point_flash <= point_flash_nxt;
            winner      <= winner_nxt;
`ifdef GAMEOVER_AUTORESTART_EN
            go_cnt      <= go_cnt_nxt;
`endif
        end
    end

    assign bus.score1      = score1;
    assign bus.score2      = score2;
    assign bus.screen_sel  = screen_sel;
    assign bus.game_active = game_active;
    assign bus.point_flash = point_flash;
    assign bus.winner      = winner;

endmodule

// File: tb/tb_match_flow_ctrl.sv
// Directed bench for match_flow_ctrl with WIN_SCORE=3, HOLD_CYCLES=4, GAMEOVER_CYCLES=10.
// Builds with or without GAMEOVER_AUTORESTART_EN.
module tb_match_flow_ctrl;

    localparam int unsigned WIN  = 3;
    localparam int unsigned HOLD = 4;
    localparam int unsigned GOC  = 10;

    localparam int M_TITLE = 0;
    localparam int M_PLAY  = 1;
    localparam int M_HOLD  = 2;
    localparam int M_GO1   = 3;
    localparam int M_GO2   = 4;

    typedef struct {
        string       tag;
        logic [1:0]  screen;
        logic [2:0]  s1;
        logic [2:0]  s2;
        logic        act;
        logic        flash;
        logic [1:0]  win;
    } exp_t;

    logic basys3_clk = 1'b0;
    logic reset      = 1'b1;
    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    match_flow_ctrl_if bus ();

    match_flow_ctrl #(
        .WIN_SCORE       (WIN),
        .HOLD_CYCLES     (HOLD),
        .GAMEOVER_CYCLES (GOC)
    ) dut (
        .basys3_clk (basys3_clk),
        .reset      (reset),
        .bus        (bus)
    );

    always #5 basys3_clk = ~basys3_clk;

    task automatic cmp(input string tag, input string fld, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s.%s observed=%0h expected=%0h", tag, fld, obs, exp);
        end
    endtask

    // Expected outputs for a screen mode and score pair.
    task automatic push_exp(input string tag, input int mode, input logic [2:0] s1, input logic [2:0] s2);
        exp_t e;
        e.tag   = tag;
        e.s1    = s1;
        e.s2    = s2;
        e.screen = 2'b00;
        e.act   = 1'b0;
        e.flash = 1'b0;
        e.win   = 2'b00;
        case (mode)
            M_PLAY:  begin e.screen = 2'b01; e.act = 1'b1; end
            M_HOLD:  begin e.screen = 2'b01; e.flash = 1'b1; end
            M_GO1:   begin e.screen = 2'b10; e.win = 2'b01; end
            M_GO2:   begin e.screen = 2'b10; e.win = 2'b10; end
            default: e.screen = 2'b00;
        endcase
        sb.push_back(e);
    endtask

    task automatic check_out();
        exp_t e;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $error("FAIL scoreboard observed=empty expected=entry");
        end else begin
            e = sb.pop_front();
            cmp(e.tag, "screen_sel",  8'(bus.screen_sel),  8'(e.screen));
            cmp(e.tag, "score1",      8'(bus.score1),      8'(e.s1));
            cmp(e.tag, "score2",      8'(bus.score2),      8'(e.s2));
            cmp(e.tag, "game_active", 8'(bus.game_active), 8'(e.act));
            cmp(e.tag, "point_flash", 8'(bus.point_flash), 8'(e.flash));
            cmp(e.tag, "winner",      8'(bus.winner),      8'(e.win));
        end
    endtask

    // Drive one cycle of pulses, then sample just after the edge.
    task automatic step(input string tag, input logic st, input logic rs, input logic p1, input logic p2,
                        input int mode, input logic [2:0] s1, input logic [2:0] s2);
        push_exp(tag, mode, s1, s2);
        bus.start_pulse   = st;
        bus.restart_pulse = rs;
        bus.point_p1      = p1;
        bus.point_p2      = p2;
        @(posedge basys3_clk);
        #1;
        bus.start_pulse   = 1'b0;
        bus.restart_pulse = 1'b0;
        bus.point_p1      = 1'b0;
        bus.point_p2      = 1'b0;
        check_out();
    endtask

    // Remaining freeze after a point: three more HOLD cycles, then PLAY.
    task automatic hold_wait(input string tag, input logic [2:0] s1, input logic [2:0] s2);
        for (int i = 0; i < int'(HOLD) - 1; i++) step(tag, 0, 0, 0, 0, M_HOLD, s1, s2);
        step({tag, "_resume"}, 0, 0, 0, 0, M_PLAY, s1, s2);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start_pulse   = 1'b0;
        bus.restart_pulse = 1'b0;
        bus.point_p1      = 1'b0;
        bus.point_p2      = 1'b0;

        // Reset for two cycles, then idle.
        reset = 1'b1;
        repeat (2) @(posedge basys3_clk);
        #1;
        push_exp("reset", M_TITLE, 0, 0);
        check_out();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) step("idle", 0, 0, 0, 0, M_TITLE, 0, 0);

        // First point and the freeze; P2 pulse during HOLD is ignored.
        step("start", 1, 0, 0, 0, M_PLAY, 0, 0);
        step("p1_pt1", 0, 0, 1, 0, M_HOLD, 1, 0);
        step("hold_p2", 0, 0, 0, 1, M_HOLD, 1, 0);
        step("hold_c2", 0, 0, 0, 0, M_HOLD, 1, 0);
        step("hold_c3", 0, 0, 0, 0, M_HOLD, 1, 0);
        step("hold_end", 0, 0, 0, 0, M_PLAY, 1, 0);

        // P1 reaches 3 and wins; start and point pulses are then ignored.
        step("p1_pt2", 0, 0, 1, 0, M_HOLD, 2, 0);
        hold_wait("h2", 2, 0);
        step("p1_win", 0, 0, 1, 0, M_GO1, 3, 0);
        step("go_start", 1, 0, 0, 0, M_GO1, 3, 0);
        step("go_p2", 0, 0, 0, 1, M_GO1, 3, 0);
        step("go_restart", 0, 1, 0, 0, M_TITLE, 3, 0);
        step("title_restart", 0, 1, 0, 0, M_TITLE, 3, 0);
        step("start2", 1, 0, 0, 0, M_PLAY, 0, 0);

        // Simultaneous points from 1/1 are dropped.
        step("p1_a", 0, 0, 1, 0, M_HOLD, 1, 0);
        hold_wait("h3", 1, 0);
        step("p2_a", 0, 0, 0, 1, M_HOLD, 1, 1);
        hold_wait("h4", 1, 1);
        step("both", 0, 0, 1, 1, M_PLAY, 1, 1);
        step("start_in_play", 1, 0, 0, 0, M_PLAY, 1, 1);

        // Restart beats a point in HOLD at 2/1.
        step("p1_b", 0, 0, 1, 0, M_HOLD, 2, 1);
        step("hold_rst_p2", 0, 1, 0, 1, M_TITLE, 2, 1);
        step("start3", 1, 0, 0, 0, M_PLAY, 0, 0);

        // Restart beats a point in PLAY at 2/1.
        step("p1_c", 0, 0, 1, 0, M_HOLD, 1, 0);
        hold_wait("h5", 1, 0);
        step("p1_d", 0, 0, 1, 0, M_HOLD, 2, 0);
        hold_wait("h6", 2, 0);
        step("p2_d", 0, 0, 0, 1, M_HOLD, 2, 1);
        hold_wait("h7", 2, 1);
        step("play_rst_p2", 0, 1, 0, 1, M_TITLE, 2, 1);
        step("start4", 1, 0, 0, 0, M_PLAY, 0, 0);

        // P2 wins 3/1.
        step("p1_e", 0, 0, 1, 0, M_HOLD, 1, 0);
        hold_wait("h8", 1, 0);
        step("p2_e", 0, 0, 0, 1, M_HOLD, 1, 1);
        hold_wait("h9", 1, 1);
        step("p2_f", 0, 0, 0, 1, M_HOLD, 1, 2);
        hold_wait("h10", 1, 2);
        step("p2_win", 0, 0, 0, 1, M_GO2, 1, 3);
`ifdef GAMEOVER_AUTORESTART_EN
        for (int i = 0; i < int'(GOC) - 1; i++) step("go_wait", 0, 0, 0, 0, M_GO2, 1, 3);
        step("go_auto", 0, 0, 0, 0, M_TITLE, 1, 3);
`else
        for (int i = 0; i < 20; i++) step("go_stay", 0, 0, 0, 0, M_GO2, 1, 3);
        step("go_restart2", 0, 1, 0, 0, M_TITLE, 1, 3);
`endif
        step("title_hold", 0, 1, 0, 0, M_TITLE, 1, 3);

        // Reset in HOLD wins over every other input.
        step("start5", 1, 0, 0, 0, M_PLAY, 0, 0);
        step("p1_g", 0, 0, 1, 0, M_HOLD, 1, 0);
        reset = 1'b1;
        step("reset_hold", 1, 1, 0, 1, M_TITLE, 0, 0);
        reset = 1'b0;
        step("post_reset", 0, 0, 0, 0, M_TITLE, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
